hazard_forward_ctrl: RTL and testbench

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_forward_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall controller for a classic 5-stage pipeline.
// Optional decode-stage write-through selects (forward_c/forward_d) when HFC_ID_BYPASS_EN is defined.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rs,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_flush,
`ifdef HFC_ID_BYPASS_EN
    output logic                  forward_c,
    output logic                  forward_d,
`endif
    output logic                  stall_active
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Cycles still owed after the detection cycle, minus the final STALL cycle.
    localparam logic [1:0] CNT_RELOAD = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX_MEM  = 2'b10;
    localparam logic [1:0] FWD_MEM_WB  = 2'b01;

    logic [REG_ADDR_W-1:0] ex_src [2];
    logic [1:0]            ex_fwd [2];

    assign ex_src[0] = id_ex_rs;
    assign ex_src[1] = id_ex_rt;

    // Each operand resolves its own EX/MEM-over-MEM/WB priority independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_ex_mem;
            logic hit_mem_wb;

            assign hit_ex_mem = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == ex_src[gi]);
            assign hit_mem_wb = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == ex_src[gi]);

            always_comb begin
                if (hit_ex_mem) begin
                    ex_fwd[gi] = FWD_EX_MEM;
                end else if (hit_mem_wb) begin
                    ex_fwd[gi] = FWD_MEM_WB;
                end else begin
                    ex_fwd[gi] = FWD_REGFILE;
                end
            end
        end
    endgenerate

    assign forward_a = ex_fwd[0];
    assign forward_b = ex_fwd[1];

`ifdef HFC_ID_BYPASS_EN
    assign forward_c = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == if_id_rs);
    assign forward_d = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == if_id_rt);
`endif

    logic hazard;

    assign hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    logic [0:0] state_q, state_d;
    logic [1:0] cnt_q,   cnt_d;
    logic       stall_d;

    // A STALL cycle ignores hazard, so a hazard on the exit cycle is picked up in the next IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hazard) begin
                        stall_d = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = CNT_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    stall_d = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by rst_n so the stall outputs release the instant reset is applied.
    logic stall_out;

    assign stall_out    = stall_d && rst_n;
    assign pc_write     = !stall_out;
    assign if_id_write  = !stall_out;
    assign id_ex_flush  = stall_out;
    assign stall_active = stall_out;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with LOAD_LAT=3; covers forwarding priority, stall length, flush and reset abort.
module tb_hazard_forward_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] if_id_rs = '0, if_id_rt = '0;
    logic          if_id_uses_rt = 1'b0;
    logic [AW-1:0] id_ex_rs = '0, id_ex_rt = '0;
    logic          id_ex_mem_read = 1'b0;
    logic [AW-1:0] ex_mem_rd = '0, mem_wb_rd = '0;
    logic          ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    forward_a, forward_b;
    logic          pc_write, if_id_write, id_ex_flush, stall_active;
`ifdef HFC_ID_BYPASS_EN
    logic          forward_c, forward_d;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_W(AW), .LOAD_LAT(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_uses_rt    (if_id_uses_rt),
        .id_ex_rs         (id_ex_rs),
        .id_ex_rt         (id_ex_rt),
        .id_ex_mem_read   (id_ex_mem_read),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .flush            (flush),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_flush      (id_ex_flush),
`ifdef HFC_ID_BYPASS_EN
        .forward_c        (forward_c),
        .forward_d        (forward_d),
`endif
        .stall_active     (stall_active)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // exp=1 means stall outputs asserted: pc_write=0, if_id_write=0, id_ex_flush=1, stall_active=1.
    task automatic check_stall(input string tag, input logic exp);
        check_eq({tag, ".pc_write"},     32'(pc_write),     32'(!exp));
        check_eq({tag, ".if_id_write"},  32'(if_id_write),  32'(!exp));
        check_eq({tag, ".id_ex_flush"},  32'(id_ex_flush),  32'(exp));
        check_eq({tag, ".stall_active"}, 32'(stall_active), 32'(exp));
    endtask

    task automatic clear_inputs();
        if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 1'b0;
        id_ex_rs = '0; id_ex_rt = '0; id_ex_mem_read = 1'b0;
        ex_mem_rd = '0; mem_wb_rd = '0;
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
        flush = 1'b0;
    endtask

    task automatic load_hazard(input logic [AW-1:0] r);
        id_ex_mem_read = 1'b1; id_ex_rt = r; if_id_rs = r;
    endtask

    initial begin
        // Reset state, with forwarding still live during reset.
        #2;
        check_stall("rst", 1'b0);
        ex_mem_rd = 5'd9; ex_mem_reg_write = 1'b1; id_ex_rs = 5'd9;
        #1;
        check_eq("rst.fwd_a", 32'(forward_a), 32'h2);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // Both stages write r3: EX/MEM wins.
        @(negedge clk);
        ex_mem_rd = 5'd3; mem_wb_rd = 5'd3; ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1; id_ex_rs = 5'd3;
        #1; check_eq("fwd.both_r3.a", 32'(forward_a), 32'h2);

        // Per-operand priority: a from EX/MEM, b from MEM/WB.
        @(negedge clk); clear_inputs();
        ex_mem_rd = 5'd4; ex_mem_reg_write = 1'b1; mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1;
        id_ex_rs = 5'd4; id_ex_rt = 5'd5;
        #1; check_eq("fwd.split.a", 32'(forward_a), 32'h2);
        check_eq("fwd.split.b", 32'(forward_b), 32'h1);

        // r0 is never forwarded.
        @(negedge clk); clear_inputs();
        ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b1; id_ex_rs = 5'd0;
        #1; check_eq("fwd.r0.a", 32'(forward_a), 32'h0);

        // Matching rd without reg_write does not forward; MEM/WB then applies.
        @(negedge clk); clear_inputs();
        ex_mem_rd = 5'd6; mem_wb_rd = 5'd6; mem_wb_reg_write = 1'b1; id_ex_rs = 5'd6; id_ex_rt = 5'd6;
        #1; check_eq("fwd.nowr.a", 32'(forward_a), 32'h1);
        check_eq("fwd.nowr.b", 32'(forward_b), 32'h1);
        mem_wb_reg_write = 1'b0;
        #1; check_eq("fwd.none.b", 32'(forward_b), 32'h0);

        // Non-hazards: rt not read, and load to r0.
        @(negedge clk); clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd6; if_id_rt = 5'd6; if_id_rs = 5'd1;
        #1; check_stall("nohaz.unused_rt", 1'b0);
        @(negedge clk); clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        #1; check_stall("nohaz.r0", 1'b0);

        // Load-use on rs: exactly 3 stall cycles, then released.
        @(negedge clk); clear_inputs(); load_hazard(5'd7);
        #1; check_stall("ld.c1", 1'b1);
        @(negedge clk); clear_inputs();
        #1; check_stall("ld.c2", 1'b1);
        @(negedge clk);
        #1; check_stall("ld.c3", 1'b1);
        @(negedge clk);
        #1; check_stall("ld.c4", 1'b0);

        // Load-use via rt: stall stays asserted though hazard is dropped.
        @(negedge clk); clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd6; if_id_rt = 5'd6; if_id_uses_rt = 1'b1; if_id_rs = 5'd1;
        #1; check_stall("ldrt.c1", 1'b1);
        @(negedge clk); clear_inputs();
        #1; check_stall("ldrt.c2", 1'b1);
        @(negedge clk);
        #1; check_stall("ldrt.c3", 1'b1);
        @(negedge clk);
        #1; check_stall("ldrt.c4", 1'b0);

        // Flush on the second stall cycle cancels it and returns to IDLE.
        @(negedge clk); clear_inputs(); load_hazard(5'd7);
        #1; check_stall("fl.c1", 1'b1);
        @(negedge clk); clear_inputs(); flush = 1'b1;
        #1; check_stall("fl.c2", 1'b0);
        @(negedge clk); flush = 1'b0;
        #1; check_stall("fl.c3", 1'b0);

        // Flush beats a fresh hazard in IDLE.
        @(negedge clk); clear_inputs(); load_hazard(5'd8); flush = 1'b1;
        #1; check_stall("fl.idle", 1'b0);

        // Reset mid-stall: immediate release, no stall after deassertion.
        @(negedge clk); clear_inputs(); load_hazard(5'd7);
        #1; check_stall("rs.c1", 1'b1);
        @(negedge clk); clear_inputs();
        #1; check_stall("rs.c2", 1'b1);
        #1; rst_n = 1'b0;
        #1; check_stall("rs.async", 1'b0);
        @(negedge clk); rst_n = 1'b1;
        #1; check_stall("rs.post1", 1'b0);
        @(negedge clk);
        #1; check_stall("rs.post2", 1'b0);

        // Hazard held through an episode: the exit cycle ignores it, next IDLE cycle restarts.
        @(negedge clk); clear_inputs(); load_hazard(5'd9);
        #1; check_stall("hold.c1", 1'b1);
        @(negedge clk); #1; check_stall("hold.c2", 1'b1);
        @(negedge clk); #1; check_stall("hold.c3", 1'b1);
        @(negedge clk); #1; check_stall("hold.c4", 1'b1);
        @(negedge clk); clear_inputs();
        #1; check_stall("hold.c5", 1'b1);
        @(negedge clk); #1; check_stall("hold.c6", 1'b1);
        @(negedge clk); #1; check_stall("hold.c7", 1'b0);

`ifdef HFC_ID_BYPASS_EN
        @(negedge clk); clear_inputs();
        mem_wb_rd = 5'd11; mem_wb_reg_write = 1'b1; if_id_rs = 5'd11; if_id_rt = 5'd12;
        #1; check_eq("byp.c", 32'(forward_c), 32'h1);
        check_eq("byp.d", 32'(forward_d), 32'h0);
        mem_wb_rd = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
        #1; check_eq("byp.r0.c", 32'(forward_c), 32'h0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
